// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers: one result bit per clock,
// followed by a single sign-correction cycle that writes HI/LO and pulses done.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opd_q, opd_d;
    logic [WIDTH-1:0]     orig_a_q, orig_a_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;
    logic                 rneg_q, rneg_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 sgn;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       trial;
    logic [2*WIDTH-1:0]   prod;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic signed_op);
        logic signed [WIDTH-1:0] sv;
        sv = v;
        return (signed_op && (sv < 0)) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] v,
                                                  input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate_2w(input logic [2*WIDTH-1:0] v,
                                                     input logic n);
        return n ? -v : v;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        orig_a_d = orig_a_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        sgn      = ~op[0];
        a_mag    = magnitude(srcA, sgn);
        b_mag    = magnitude(srcB, sgn);
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opd_q};
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        trial    = rem_sh - {1'b0, opd_q};
        prod     = negate_2w(acc_q, neg_q);

        case (state_q)
            IDLE: begin
                if (hi_we) hi_d = wd;
                if (lo_we) lo_d = wd;
                if (start) begin
                    // acc low half holds the multiplier (mul) or dividend (div);
                    // opd holds the multiplicand (mul) or divisor (div).
                    is_div_d = op[1];
                    opd_d    = op[1] ? b_mag : a_mag;
                    acc_d    = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                    orig_a_d = srcA;
                    neg_d    = sgn & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                    rneg_d   = sgn & srcA[WIDTH-1];
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (is_div_q) begin
                    if (!trial[WIDTH])
                        acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else if (acc_q[0]) begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end else begin
                    acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
                end
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    if (opd_q == '0) begin
                        lo_d = '1;
                        hi_d = orig_a_q;
                    end else begin
                        lo_d = negate_w(acc_q[WIDTH-1:0], neg_q);
                        hi_d = negate_w(acc_q[2*WIDTH-1:WIDTH], rneg_q);
                    end
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            orig_a_q <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            orig_a_q <= orig_a_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
